// File: rtl/uart_pkg.sv
// Shared FSM encoding and sizing helpers for the UART transmit arbiter.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

  // Bits needed to hold values 0..n-1 (minimum 1 for n=2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr_i, wrapping.
// Zero latency; gnt_vld_o stays low while en_i is low.
module rr_arbiter import uart_pkg::*; #(
  parameter  int N   = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           en_i,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_vld_o
);

  int idx;

  // Scan from the farthest offset down so the nearest request to the pointer wins.
  always_comb begin
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (en_i && req_i[idx]) begin
        gnt_id_o  = IDW'(idx);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin grant, issue strobe, ack on frame end.
// Issue 1 cycle after a request seen in IDLE; ack 1 cycle after TX_BUSY falls; stalls while TX_BUSY is high.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int TIMEOUT = 16,
  localparam int ID_W    = clog2(NUM_REQ),
  localparam int CNT_W   = clog2(TIMEOUT) + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]        REQ_PAR_EN,
  output logic [NUM_REQ-1:0]        GNT_ACK,
  output logic [ID_W-1:0]           GNT_ID,
  output logic                      ARB_BUSY,
  output logic                      ERR_TIMEOUT,
  output logic [DATA_W-1:0]         TX_P_DATA,
  output logic                      TX_DATA_VALID,
  output logic                      TX_PAR_EN,
  input  logic                      TX_BUSY
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_q, par_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ID_W-1:0]     win_id;
  logic                win_vld;
  logic [ID_W-1:0]     ptr_next;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i     (REQ),
    .ptr_i     (ptr_q),
    .en_i      ((state_q == ARB_IDLE) && !TX_BUSY),
    .gnt_id_o  (win_id),
    .gnt_vld_o (win_vld)
  );

  assign ptr_next = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    data_d   = data_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    vld_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          state_d  = ARB_ISSUE;
          gnt_id_d = win_id;
          data_d   = REQ_DATA[int'(win_id)*DATA_W +: DATA_W];
          par_d    = REQ_PAR_EN[win_id];
          vld_d    = 1'b1;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT_BUSY;
        cnt_d   = '0;
      end
      ARB_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = ARB_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Give up on a silent transmitter; the requester loses its turn.
          if (cnt_d == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            ptr_d   = ptr_next;
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_WAIT_DONE: begin
        if (!TX_BUSY) begin
          ack_d[gnt_id_q] = 1'b1;
          ptr_d           = ptr_next;
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
    end
  end

  assign GNT_ACK       = ack_q;
  assign GNT_ID        = gnt_id_q;
  assign ARB_BUSY      = busy_q;
  assign ERR_TIMEOUT   = err_q;
  assign TX_P_DATA     = data_q;
  assign TX_DATA_VALID = vld_q;
  assign TX_PAR_EN     = par_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a frame-level model plans each grant and transmitter response,
// pushes the expected issue/completion, and a monitor compares the DUT outputs every cycle.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  typedef struct { int id; logic [DW-1:0] dat; bit par; int cyc; } iss_t;
  typedef struct { int id; bit err; int icyc; int cyc; } cmp_t;

  logic            CLK, RST;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_PAR_EN;
  logic [N-1:0]    GNT_ACK;
  logic [1:0]      GNT_ID;
  logic            ARB_BUSY, ERR_TIMEOUT;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_DATA_VALID, TX_PAR_EN, TX_BUSY;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_PAR_EN(REQ_PAR_EN),
    .GNT_ACK(GNT_ACK), .GNT_ID(GNT_ID), .ARB_BUSY(ARB_BUSY), .ERR_TIMEOUT(ERR_TIMEOUT),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .TX_PAR_EN(TX_PAR_EN), .TX_BUSY(TX_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 0;
  iss_t iq[$];
  cmp_t cq[$];

  // Reference model state: requester levels, pending requests, and the round-robin pointer.
  int            ptr;
  bit [N-1:0]    pend, req_lvl, par_v;
  logic [DW-1:0] dat [N];
  int            rem [N];

  int            last_id;
  logic [DW-1:0] last_dat;
  bit            last_par;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic miss(input string nm, input int exp_cyc);
    n_chk++;
    n_fail++;
    $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", nm, exp_cyc, cyc);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt_ack"},  int'(GNT_ACK), 0);
    chk({tag, "_gnt_id"},   int'(GNT_ID), 0);
    chk({tag, "_arb_busy"}, int'(ARB_BUSY), 0);
    chk({tag, "_err"},      int'(ERR_TIMEOUT), 0);
    chk({tag, "_tx_data"},  int'(TX_P_DATA), 0);
    chk({tag, "_tx_vld"},   int'(TX_DATA_VALID), 0);
    chk({tag, "_tx_par"},   int'(TX_PAR_EN), 0);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ[i]              = req_lvl[i];
      REQ_DATA[i*DW +: DW] = dat[i];
      REQ_PAR_EN[i]       = par_v[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // mode: 0 random (may stall), 1 first frame stalls, 2 first frame busy 1 cycle after issue for 11, 3 never stalls
  task automatic run_episode(input logic [N-1:0] mask, input logic [N*DW-1:0] dats,
                             input logic [N-1:0] pars, input logic [2*N-1:0] rems,
                             input int block, input int mode);
    int w, v, e, d, len, drop_at;
    bit stuck, first;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        pend[i] = 1'b1; req_lvl[i] = 1'b1;
        dat[i] = dats[i*DW +: DW]; par_v[i] = pars[i];
        rem[i] = int'(rems[2*i +: 2]);
      end
    end
    if (block > 0) begin
      TX_BUSY = 1'b1;
      drive();
      repeat (block) @(negedge CLK);
      TX_BUSY = 1'b0;
    end
    drive();
    first = 1'b1;
    while (pend != 0) begin
      w     = pick();
      v     = cyc + 1;
      stuck = (mode == 1 && first) || (mode == 0 && $urandom_range(0, 5) == 0);
      d     = (mode == 2 && first) ? 1  : int'($urandom_range(1, 4));
      len   = (mode == 2 && first) ? 11 : int'($urandom_range(1, 12));
      e     = stuck ? v + TMO : v + d + len + 1;
      drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(v, e - 1)) : -1;
      iq.push_back('{w, dat[w], par_v[w], v});
      cq.push_back('{w, stuck, v, e});
      pend[w] = 1'b0;
      first   = 1'b0;
      @(negedge CLK);
      while (cyc < e) begin
        TX_BUSY = !stuck && (cyc - v >= d) && (cyc - v < d + len);
        if (cyc == v) dat[w] = 8'($urandom);
        if (cyc == drop_at) req_lvl[w] = 1'b0;
        drive();
        @(negedge CLK);
      end
      TX_BUSY = 1'b0;
      ptr = (w + 1) % N;
      if (rem[w] > 0) begin
        rem[w]--; pend[w] = 1'b1; req_lvl[w] = 1'b1;
        dat[w] = 8'($urandom); par_v[w] = 1'($urandom);
      end else begin
        req_lvl[w] = 1'b0;
      end
      drive();
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an issue or a completion.
  initial begin
    iss_t it;
    cmp_t ct;
    bit   exp_busy;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        last_id = 0; last_dat = '0; last_par = 1'b0;
      end else begin
        if (iq.size() > 0 && iq[0].cyc < cyc) begin miss("issue", iq[0].cyc); it = iq.pop_front(); end
        if (TX_DATA_VALID) begin
          if (iq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL issue_unexpected at cycle %0d: TX_DATA_VALID=1, required 0", cyc);
          end else begin
            it = iq.pop_front();
            chk("issue_cycle", cyc, it.cyc);
            chk("issue_id",    int'(GNT_ID), it.id);
            chk("issue_data",  int'(TX_P_DATA), int'(it.dat));
            chk("issue_par",   int'(TX_PAR_EN), int'(it.par));
            last_id = it.id; last_dat = it.dat; last_par = it.par;
          end
        end
        if (cq.size() > 0 && cq[0].cyc < cyc) begin miss("completion", cq[0].cyc); ct = cq.pop_front(); end
        if (GNT_ACK != 0 || ERR_TIMEOUT) begin
          if (cq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL completion_unexpected at cycle %0d: ack=0x%0h err=%0d, required none", cyc, GNT_ACK, ERR_TIMEOUT);
          end else begin
            ct = cq.pop_front();
            chk("completion_cycle", cyc, ct.cyc);
            chk("ack_vector", int'(GNT_ACK), ct.err ? 0 : (1 << ct.id));
            chk("err_pulse",  int'(ERR_TIMEOUT), int'(ct.err));
          end
        end
        exp_busy = (cq.size() > 0) && (cq[0].icyc <= cyc) && (cyc < cq[0].cyc);
        chk("arb_busy",     int'(ARB_BUSY), int'(exp_busy));
        chk("gnt_id_hold",  int'(GNT_ID), last_id);
        chk("tx_data_hold", int'(TX_P_DATA), int'(last_dat));
        chk("tx_par_hold",  int'(TX_PAR_EN), int'(last_par));
      end
    end
  end

  initial begin
    int v, w;
    RST = 1'b0; TX_BUSY = 1'b0; REQ = '0; REQ_DATA = '0; REQ_PAR_EN = '0;
    ptr = 0; pend = '0; req_lvl = '0; par_v = '0;
    for (int i = 0; i < N; i++) begin dat[i] = '0; rem[i] = 0; end
    repeat (3) @(negedge CLK);
    chk_reset("por");
    RST = 1'b1;
    @(negedge CLK);
    mon_en = 1'b1;

    // All four requesting, requester 0 asks twice: order 0,1,2,3,0.
    run_episode(4'b1111, 32'h13121110, 4'b0101, 8'b00_00_00_01, 0, 3);
    // Single request from requester 1.
    run_episode(4'b0010, 32'h0000A500, 4'b0010, 8'h00, 0, 2);
    // Pointer at 2 with requesters 0,1,3: order 3,0,1.
    run_episode(4'b1011, 32'h44332211, 4'b1001, 8'h00, 0, 3);
    // Stuck transmitter on requester 2, then requester 1 is served.
    run_episode(4'b0110, 32'h00C0B000, 4'b0100, 8'h00, 0, 1);
    // Foreign transmitter activity for 20 cycles blocks the grant.
    run_episode(4'b0001, 32'h0000005E, 4'b0001, 8'h00, 20, 3);

    // Leave the pointer at 3, then abort a grant to requester 3 mid-frame.
    run_episode(4'b0100, 32'h005A0000, 4'b0000, 8'h00, 0, 3);
    pend = 4'b1000; req_lvl = 4'b1000; dat[3] = 8'hC3; par_v[3] = 1'b1;
    drive();
    w = pick();
    v = cyc + 1;
    iq.push_back('{w, dat[w], par_v[w], v});
    cq.push_back('{w, 1'b0, v, v + 1000});
    pend = '0;
    @(negedge CLK);
    while (cyc < v + 4) begin
      TX_BUSY = (cyc >= v + 1);
      @(negedge CLK);
    end
    mon_en = 1'b0;
    #1 RST = 1'b0;
    #1 chk_reset("async_rst");
    iq.delete(); cq.delete();
    TX_BUSY = 1'b0; req_lvl = '0; drive();
    @(negedge CLK);
    chk_reset("held_rst");
    RST = 1'b1;
    ptr = 0;
    @(negedge CLK);
    mon_en = 1'b1;
    run_episode(4'b1100, 32'h77660000, 4'b0100, 8'h00, 0, 3);

    repeat (40) begin
      run_episode(4'($urandom_range(1, 15)), $urandom, 4'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    chk("issue_queue_drained", iq.size(), 0);
    chk("completion_queue_drained", cq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte-level requesters.
- Selects a requester, latches its byte and parity-enable, and issues a one-cycle valid to the transmitter.
- Tracks the transmitter busy flag through the frame, then returns a completion ack to the winning requester.
- Sits between client logic (register block, debug port, etc.) and the UART TX datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT, 16, max cycles to wait for TX_BUSY to rise after issue.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- REQ  in  NUM_REQ  per-requester transmit request (level)
- REQ_DATA  in  NUM_REQ*DATA_W  per-requester byte; slice i = bits [i*DATA_W +: DATA_W]
- REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
- GNT_ACK  out  NUM_REQ  one-cycle completion pulse to the granted requester
- GNT_ID  out  clog2(NUM_REQ)  index of the current/last granted requester
- ARB_BUSY  out  1  high whenever state is not IDLE
- ERR_TIMEOUT  out  1  one-cycle pulse when the transmitter did not respond
- TX_P_DATA  out  DATA_W  byte to the transmitter
- TX_DATA_VALID  out  1  one-cycle issue strobe to the transmitter
- TX_PAR_EN  out  1  parity enable to the transmitter
- TX_BUSY  in  1  transmitter busy flag

Behaviour:
- Reset: state IDLE; rr pointer 0; GNT_ACK 0; GNT_ID 0; ARB_BUSY 0; ERR_TIMEOUT 0; TX_P_DATA 0; TX_DATA_VALID 0; TX_PAR_EN 0; timeout counter 0. All outputs are registered.
- Arbitration (IDLE only):
  - Search starts at the rr pointer, incrementing modulo NUM_REQ.
  - The first i with REQ[i]=1 wins.
  - Arbitration happens only when TX_BUSY=0.
- Transition IDLE -> ISSUE, on the edge where the winner is found:
  - Latch REQ_DATA[i] into TX_P_DATA and REQ_PAR_EN[i] into TX_PAR_EN.
  - Set GNT_ID=i and TX_DATA_VALID=1.
- ISSUE (1 cycle):
  - TX_DATA_VALID is high for exactly this cycle.
  - Next state WAIT_BUSY, counter cleared.
- WAIT_BUSY:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise the counter increments.
  - Counter reaching TIMEOUT-1 -> pulse ERR_TIMEOUT, no GNT_ACK, rr pointer advances past i, state IDLE.
- WAIT_DONE:
  - TX_BUSY=0 -> GNT_ACK[i]=1 for one cycle, rr pointer = (i+1) mod NUM_REQ, state IDLE.
- TX_P_DATA and TX_PAR_EN hold their latched values from ISSUE until the next grant; they are stable for the whole frame.
- Latency:
  - REQ rising with TX_BUSY=0 and state IDLE gives TX_DATA_VALID high 1 cycle later.
  - GNT_ACK asserts on the cycle after TX_BUSY falls.
  - The next issue is possible 1 cycle after GNT_ACK.
- Requesters hold REQ until GNT_ACK. Data is sampled only at grant.
- REQ deasserted mid-frame: ignored. The frame completes and the ack is still pulsed.
- REQ[i] still high in the ack cycle: treated as a new request. It competes at the next arbitration, and with the pointer advanced, other requesters get priority.
- TX_BUSY=1 while in IDLE (foreign activity): no grant until it falls.
- Simultaneous requests: strictly round-robin, so no requester waits more than NUM_REQ-1 frames.
- Async reset mid-frame: immediate return to reset values; no ack or error is issued for the aborted grant.

Decomposition:
- Shared package uart_pkg:
  - state encoding (ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE), 2 bits;
  - default DATA_W=8;
  - clog2 function.
- One natural sub-module: rr_arbiter.
  - Combinational priority search given REQ, pointer and enable.
  - Outputs: winner index and a valid flag.
  - Reusable for other shared resources.

Test Plan:
- Single request: REQ=4'b0010, REQ_DATA[1]=8'hA5, PAR_EN[1]=1, model asserts TX_BUSY 1 cycle after valid for 11 cycles -> TX_DATA_VALID one cycle with TX_P_DATA=8'hA5 and TX_PAR_EN=1; GNT_ACK=4'b0010 exactly one cycle after TX_BUSY falls; GNT_ID=1.
- All four request continuously, bytes 8'h10..8'h13 -> issue order 0,1,2,3,0; each GNT_ACK one-hot; no requester skipped.
- Pointer fairness: pointer=2 (after a grant to requester 1), REQ=4'b1011 -> requester 3 wins, then 0, then 1.
- Transmitter stuck (TX_BUSY never rises), TIMEOUT=16 -> ERR_TIMEOUT one pulse 16 cycles after ISSUE; no GNT_ACK; state IDLE; next requester served.
- TX_BUSY=1 held externally for 20 cycles while REQ=4'b0001 -> no TX_DATA_VALID until TX_BUSY falls, then issue on the next cycle.
- RST low during WAIT_DONE -> all outputs 0 immediately; after release, a pending REQ=4'b0100 is granted from pointer 0 (requester 2 issued).
